// File: rtl/dma_read_fifo_drain_if.sv
// Bundle between the DMA read FIFO, the drain engine and the PCI master.
// master = drain engine side, slave = FIFO/PCI/control side.
interface dma_read_fifo_drain_if #(
  parameter int LEN_BITS = 10
);
  logic                xfer_start;
  logic [LEN_BITS-1:0] xfer_len;
  logic                xfer_busy;
  logic                xfer_done;
  logic                fifo_wr_en;
  logic [31:0]         fifo_dout;
  logic                fifo_rd_en;
  logic                fifo_delete_en;
  logic                fifo_undo;
  logic [31:0]         pci_ad_out;
  logic                pci_data_vld;
  logic                pci_data_ack;
  logic                pci_abort;

  modport master (
    input  xfer_start, xfer_len,
    input  fifo_wr_en, fifo_dout,
    input  pci_data_ack, pci_abort,
    output xfer_busy, xfer_done,
    output fifo_rd_en, fifo_delete_en,
    output fifo_undo,
    output pci_ad_out, pci_data_vld
  );

  modport slave (
    output xfer_start, xfer_len,
    output fifo_wr_en, fifo_dout,
    output pci_data_ack, pci_abort,
    input  xfer_busy, xfer_done,
    input  fifo_rd_en, fifo_delete_en,
    input  fifo_undo,
    input  pci_ad_out, pci_data_vld
  );
endinterface

// File: rtl/dma_read_fifo_drain.sv
// Drains the DMA read FIFO into the PCI master one word at a time,
// deleting on ack and rewinding the FIFO on disconnect/retry.
module dma_read_fifo_drain #(
  parameter int FIFO_DEPTH_BITS = 2,
  parameter int FIFO_DEPTH      = 2**FIFO_DEPTH_BITS,
  parameter int LEN_BITS        = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  dma_read_fifo_drain_if.master bus
);
  localparam int CW = FIFO_DEPTH_BITS + 1;
  localparam int LW = LEN_BITS + 1;
  localparam logic [CW-1:0] DEPTH_W = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RESTART
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] undeleted_q, undeleted_d;
  logic [CW-1:0] unread_q, unread_d;
  logic [LW-1:0] remaining_q, remaining_d;
  logic [LW-1:0] to_load_q, to_load_d;
  logic [31:0]   ad_q, ad_d;
  logic          vld_q, vld_d;
  logic          undo_q, busy_q;
  logic          done_q, done_d;
  logic          ack, finish, abort;
  logic          rd_en, del_en;

  assign ack    = bus.pci_data_ack & vld_q;
  assign finish = (state_q == RUN) & ack
                & (remaining_q == LW'(1));
  // completion outranks a coincident abort
  assign abort  = (state_q == RUN) & bus.pci_abort
                & ~finish;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      undo_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      undo_q  <= (state_d == RESTART);
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.xfer_start) begin
          if (bus.xfer_len == '0) done_d = 1'b1;
          else state_d = RUN;
        end
      end
      RUN: begin
        if (finish) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (abort) begin
          state_d = RESTART;
        end
      end
      RESTART: state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_en  = 1'b0;
    del_en = 1'b0;
    if (state_q == RUN) begin
      del_en = ack;
      rd_en  = ~abort
             & (to_load_q != '0)
             & (unread_q != '0)
             & (~vld_q | ack);
    end
  end

  always_comb begin
    undeleted_d = undeleted_q
                + CW'(bus.fifo_wr_en)
                - CW'(del_en);
    unread_d    = unread_q
                + CW'(bus.fifo_wr_en)
                - CW'(rd_en);
    remaining_d = remaining_q;
    to_load_d   = to_load_q;
    ad_d        = ad_q;
    vld_d       = vld_q;
    // rewind: every undeleted word becomes readable again
    if (state_q == RESTART) begin
      unread_d  = undeleted_q + CW'(bus.fifo_wr_en);
      to_load_d = remaining_q;
    end
    if ((state_q == IDLE) && bus.xfer_start) begin
      remaining_d = LW'(bus.xfer_len);
      to_load_d   = LW'(bus.xfer_len);
    end
    if (del_en) remaining_d = remaining_q - LW'(1);
    if (rd_en) begin
      ad_d      = bus.fifo_dout;
      vld_d     = 1'b1;
      to_load_d = to_load_q - LW'(1);
    end else if (ack | abort) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      undeleted_q <= '0;
      unread_q    <= '0;
      remaining_q <= '0;
      to_load_q   <= '0;
      ad_q        <= '0;
      vld_q       <= 1'b0;
    end else begin
      undeleted_q <= undeleted_d;
      unread_q    <= unread_d;
      remaining_q <= remaining_d;
      to_load_q   <= to_load_d;
      ad_q        <= ad_d;
      vld_q       <= vld_d;
    end
  end

  assign bus.fifo_rd_en     = rd_en;
  assign bus.fifo_delete_en = del_en;
  assign bus.fifo_undo      = undo_q;
  assign bus.pci_ad_out     = ad_q;
  assign bus.pci_data_vld   = vld_q;
  assign bus.xfer_busy      = busy_q;
  assign bus.xfer_done      = done_q;

  a_no_overflow : assert property (
    @(posedge clk) disable iff (!reset_n)
    !(bus.fifo_wr_en && !del_en && (undeleted_q == DEPTH_W))
  ) else $error("dma_read_fifo_drain: FIFO write beyond depth");
endmodule

// File: tb/tb_dma_read_fifo_drain.sv
// Scoreboard bench for dma_read_fifo_drain with a 4-deep FIFO model.
// Driver pushes expected words; the monitor pops them on every ack.
module tb_dma_read_fifo_drain;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  dma_read_fifo_drain_if #(.LEN_BITS(10)) bus ();

  dma_read_fifo_drain #(
    .FIFO_DEPTH_BITS(2),
    .LEN_BITS(10)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_rd, n_del, n_undo, n_done, done_cyc, c0;
  logic [31:0] exp_q[$];
  int ack_cyc[$];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, req);
  endtask

  // FIFO model: read pointer, delete (backup) pointer, write pointer
  logic [31:0] mem [4];
  logic [1:0]  wp, rp, dp;
  logic [31:0] wdata;
  assign bus.fifo_dout = mem[rp];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
      dp <= '0;
    end else begin
      if (bus.fifo_wr_en) begin
        mem[wp] <= wdata;
        wp <= wp + 2'd1;
      end
      if (bus.fifo_undo) rp <= dp;
      else if (bus.fifo_rd_en) rp <= rp + 2'd1;
      if (bus.fifo_delete_en) dp <= dp + 2'd1;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.fifo_rd_en) n_rd++;
      if (bus.fifo_delete_en) n_del++;
      if (bus.fifo_undo) begin
        n_undo++;
        chk("undo_excl",
            64'({bus.fifo_delete_en, bus.fifo_rd_en}), 64'(0));
      end
      if (bus.xfer_done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (bus.pci_data_vld && bus.pci_data_ack) begin
        ack_cyc.push_back(cyc);
        chk("del_on_ack", 64'(bus.fifo_delete_en), 64'(1));
        if (exp_q.size() == 0)
          chk("sb_unexpected", 64'(bus.pci_ad_out), 64'hdead);
        else
          chk("sb_word", 64'(bus.pci_ad_out), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    n_rd = 0;
    n_del = 0;
    n_undo = 0;
    n_done = 0;
    done_cyc = -1;
    ack_cyc.delete();
  endtask

  task automatic push_word(input logic [31:0] w);
    wdata = w;
    bus.fifo_wr_en = 1'b1;
    tick();
    bus.fifo_wr_en = 1'b0;
  endtask

  task automatic fill(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      push_word(base + 32'(i));
      exp_q.push_back(base + 32'(i));
    end
  endtask

  task automatic start(input int len);
    bus.xfer_len = 10'(len);
    bus.xfer_start = 1'b1;
    c0 = cyc;
    tick();
    bus.xfer_start = 1'b0;
  endtask

  task automatic wait_vld(input string nm);
    int n = 0;
    while (!bus.pci_data_vld && n < 30) begin
      tick();
      n++;
    end
    if (!bus.pci_data_vld) chk(nm, 64'(0), 64'(1));
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (n_done < 1 && n < 40) begin
      tick();
      n++;
    end
    chk(nm, 64'(n_done), 64'(1));
  endtask

  task automatic abort_case(input logic with_ack,
                            input logic [31:0] base,
                            input int exp_rd);
    int k;
    clr();
    fill(base, 3);
    bus.pci_data_ack = 1'b0;
    start(3);
    wait_vld("ab_vld_a");
    bus.pci_data_ack = 1'b1;
    tick();
    bus.pci_data_ack = with_ack;
    bus.pci_abort = 1'b1;
    k = cyc;
    tick();
    bus.pci_data_ack = 1'b0;
    bus.pci_abort = 1'b0;
    chk("ab_undo", 64'(bus.fifo_undo), 64'(1));
    chk("ab_vld_clr", 64'(bus.pci_data_vld), 64'(0));
    wait_vld("ab_vld_replay");
    chk("ab_replay_lat", 64'(cyc), 64'(k + 3));
    bus.pci_data_ack = 1'b1;
    wait_done("ab_done");
    bus.pci_data_ack = 1'b0;
    chk("ab_del", 64'(n_del), 64'(3));
    chk("ab_rd", 64'(n_rd), 64'(exp_rd));
    chk("ab_undo_cnt", 64'(n_undo), 64'(1));
  endtask

  initial begin
    int w1, w2;
    bus.xfer_start = 1'b0;
    bus.xfer_len = '0;
    bus.fifo_wr_en = 1'b0;
    bus.pci_data_ack = 1'b0;
    bus.pci_abort = 1'b0;
    wdata = '0;
    clr();
    #12;
    chk("rst_outs",
        64'({bus.xfer_busy, bus.xfer_done, bus.fifo_rd_en,
             bus.fifo_delete_en, bus.fifo_undo,
             bus.pci_data_vld, bus.pci_ad_out}), 64'(0));
    tick();
    reset_n = 1'b1;
    tick();

    // stream four words back to back
    clr();
    fill(32'hA000_0000, 4);
    bus.pci_data_ack = 1'b1;
    start(4);
    chk("t1_busy", 64'(bus.xfer_busy), 64'(1));
    wait_done("t1_done");
    bus.pci_data_ack = 1'b0;
    chk("t1_first", 64'(ack_cyc.size() > 0 ? ack_cyc[0] : -1),
        64'(c0 + 2));
    chk("t1_last", 64'(ack_cyc.size() > 3 ? ack_cyc[3] : -1),
        64'(c0 + 5));
    chk("t1_done_cyc", 64'(done_cyc), 64'(c0 + 6));
    chk("t1_del", 64'(n_del), 64'(4));
    chk("t1_rd", 64'(n_rd), 64'(4));
    chk("t1_busy_lo", 64'(bus.xfer_busy), 64'(0));

    // abort while B presented, then abort coincident with B's ack
    abort_case(1'b0, 32'hB000_0000, 4);
    abort_case(1'b1, 32'hC000_0000, 3);

    // words trickle in, one per 5 cycles
    clr();
    bus.pci_data_ack = 1'b1;
    start(2);
    tick();
    tick();
    w1 = cyc;
    push_word(32'hD000_0001);
    exp_q.push_back(32'hD000_0001);
    repeat (4) tick();
    w2 = cyc;
    push_word(32'hD000_0002);
    exp_q.push_back(32'hD000_0002);
    wait_done("t4_done");
    bus.pci_data_ack = 1'b0;
    chk("t4_lat1", 64'(ack_cyc.size() > 0 ? ack_cyc[0] : -1),
        64'(w1 + 2));
    chk("t4_lat2", 64'(ack_cyc.size() > 1 ? ack_cyc[1] : -1),
        64'(w2 + 2));
    chk("t4_done_cyc", 64'(done_cyc), 64'(w2 + 3));

    // abort in IDLE ignored; empty transfer
    clr();
    bus.pci_abort = 1'b1;
    tick();
    bus.pci_abort = 1'b0;
    tick();
    chk("t5_idle_abort",
        64'({bus.xfer_busy, bus.fifo_undo}), 64'(0));
    start(0);
    chk("t5_done", 64'(bus.xfer_done), 64'(1));
    chk("t5_busy", 64'(bus.xfer_busy), 64'(0));
    tick();
    chk("t5_done_pulse", 64'(bus.xfer_done), 64'(0));
    tick();
    chk("t5_no_strobes", 64'(n_rd + n_del + n_undo), 64'(0));

    // async reset mid-transfer, then a clean transfer
    clr();
    fill(32'hE000_0000, 2);
    start(2);
    wait_vld("t6_vld");
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_rst",
        64'({bus.xfer_busy, bus.xfer_done, bus.fifo_rd_en,
             bus.fifo_delete_en, bus.fifo_undo,
             bus.pci_data_vld, bus.pci_ad_out}), 64'(0));
    exp_q.delete();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    clr();
    fill(32'hF000_0000, 2);
    bus.pci_data_ack = 1'b1;
    start(2);
    wait_done("t6_done");
    bus.pci_data_ack = 1'b0;
    chk("t6_first", 64'(ack_cyc.size() > 0 ? ack_cyc[0] : -1),
        64'(c0 + 2));
    chk("t6_del", 64'(n_del), 64'(2));

    tick();
    chk("sb_empty", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
